dm9000a_bus_ctrl: RTL and testbench
===================================

// Module: dm9000a_bus_ctrl
// PURPOSE
//  Host-side bus cycle engine for the DM9000A Ethernet controller on the 50MHz system clock.
//  Turns one-at-a-time register/FIFO requests from the real-time data feed logic into timed pin cycles:
//  CS#, CMD, IOR#, IOW# and the 16-bit data bus.
//  Returns read data and a completion pulse for each request.
//  Pairs with the 25MHz controller clock generator in the Ethernet front end.
// PARAMETERS
//  SETUP_CYC    1  clk cycles CS#/CMD/write data valid before strobe falls (legal 1..15)
//  STROBE_CYC   2  clk cycles IOR#/IOW# held low (legal 1..15)
//  HOLD_CYC     1  clk cycles CS#/CMD/write data held after strobe rises (legal 1..15)
//  RECOVER_CYC  2  clk cycles CS# high, bus released, before next request is accepted (legal 1..15)
// PORTS
//  clk            in   1   system clock, 50MHz
//  reset_n        in   1   asynchronous active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   engine idle; request accepted on clk edge when req_valid & req_ready
//  req_write      in   1   1 = write cycle, 0 = read cycle
//  req_cmd        in   1   value driven on CMD pin (0 = index port, 1 = data port)
//  req_wdata      in   16  write data
//  rsp_valid      out  1   one-cycle completion pulse (reads and writes)
//  rsp_rdata      out  16  read data; valid with rsp_valid on reads; holds last read otherwise
//  enet_cs_n      out  1   chip select, active low
//  enet_cmd       out  1   CMD pin
//  enet_ior_n     out  1   read strobe, active low
//  enet_iow_n     out  1   write strobe, active low
//  enet_data_out  out  16  data to pad
//  enet_data_oe   out  1   pad output enable (top level builds the tristate)
//  enet_data_in   in  16  data from pad
// BEHAVIOUR
//  Reset (async, immediate): state IDLE.
//   Output reset values: enet_cs_n=1, enet_ior_n=1, enet_iow_n=1, enet_cmd=0, enet_data_out=0,
//   enet_data_oe=0, rsp_valid=0, rsp_rdata=0.
//   req_ready=1 once reset_n is high.
//  All pin outputs are registered; none is combinational from request inputs.
//  req_ready = (state==IDLE).
//  Accept edge: req_write, req_cmd and req_wdata are captured. Later changes on the request inputs are ignored.
//  States:
//   IDLE -> SETUP on accept.
//   SETUP -> STROBE -> HOLD -> RECOVER -> IDLE; each state lasts its *_CYC count, via a 4-bit down-counter.
//  Pins per state:
//   SETUP: cs_n=0; cmd=captured; for writes data_out=captured and oe=1.
//   STROBE: as SETUP, plus ior_n=0 (read) or iow_n=0 (write).
//   HOLD: strobes=1; cs_n, cmd, data_out and oe unchanged.
//   RECOVER/IDLE: cs_n=1, oe=0; cmd and data_out keep their last values.
//  Read sample: enet_data_in is registered into rsp_rdata on the clk edge that ends the last STROBE cycle.
//  rsp_valid is high for exactly the first HOLD cycle.
//  Timing (defaults): accept at edge 0, cs_n low during cycles 1..4, strobe low during cycles 2..3, rsp_valid in cycle 4.
//   req_ready returns in cycle 7.
//   Accept-to-accept minimum = 1+SETUP+STROBE+HOLD+RECOVER = 7 cycles.
//  req_valid outside IDLE: ignored, no queueing. The requester holds req_valid until it is accepted.
//  Reset mid-cycle: strobes and CS# go high and oe goes low asynchronously; no rsp_valid; the request is dropped.
//  Illegal parameter value 0 is a synthesis-time error (generate-time check), not runtime behaviour.
// TESTING
//  Write index: req_write=1, req_cmd=0, wdata=16'h0028
//   -> cs_n low 4 cycles, iow_n low cycles 2-3, data_out=0028 with oe=1 throughout, ior_n stays 1, rsp_valid in cycle 4.
//  Read data: req_write=0, req_cmd=1, enet_data_in=16'h0A46 during STROBE, 16'hFFFF otherwise
//   -> rsp_rdata=0A46 with rsp_valid, oe never 1, iow_n stays 1.
//  Back-to-back: req_valid held high over 3 requests -> accepts exactly 7 cycles apart, cs_n high for >=2 cycles between cycles.
//  Parameter sweep: SETUP=2, STROBE=4, HOLD=3, RECOVER=1 -> strobe low exactly 4 cycles, accept spacing 11, read sampled at end of cycle 6.
//  Reset mid-STROBE: reset_n low in cycle 2 -> iow_n/cs_n=1 and oe=0 before the next edge, no rsp_valid, req_ready=1 after release.
//  Input stability: toggle req_wdata/req_cmd every cycle after accept -> pins keep the captured values for the whole bus cycle.

Source files
------------

// File: rtl/dm9000a_bus_ctrl_if.sv
// Request/response handshake plus DM9000A pin bundle between the data-feed logic and the bus engine.
// The engine connects through 'slave'; the requester and pad logic use 'master'.
interface dm9000a_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_cmd;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        enet_cs_n;
  logic        enet_cmd;
  logic        enet_ior_n;
  logic        enet_iow_n;
  logic [15:0] enet_data_out;
  logic        enet_data_oe;
  logic [15:0] enet_data_in;

  modport slave (
    input  req_valid, req_write, req_cmd, req_wdata, enet_data_in,
    output req_ready, rsp_valid, rsp_rdata,
    output enet_cs_n, enet_cmd, enet_ior_n, enet_iow_n, enet_data_out, enet_data_oe
  );

  modport master (
    output req_valid, req_write, req_cmd, req_wdata, enet_data_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  enet_cs_n, enet_cmd, enet_ior_n, enet_iow_n, enet_data_out, enet_data_oe
  );
endinterface

// File: rtl/dm9000a_bus_ctrl.sv
// DM9000A host bus cycle engine: one request at a time becomes a timed CS#/CMD/IOR#/IOW# cycle.
// All pins come from flops; each pin flop is loaded with the value for the state being entered.
module dm9000a_bus_ctrl #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  dm9000a_bus_ctrl_if.slave   bus
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("SETUP_CYC must be in 1..15");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("STROBE_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("HOLD_CYC must be in 1..15");
  end
  if (RECOVER_CYC < 1 || RECOVER_CYC > 15) begin : g_bad_recover
    $error("RECOVER_CYC must be in 1..15");
  end

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        accept_s;
  logic        write_r, write_s;
  logic        active_s, strobe_s, sample_s;
  logic        cs_n_s, ior_n_s, iow_n_s, oe_s;
  logic        cs_n_r, ior_n_r, iow_n_r, oe_r, cmd_r, rsp_valid_r;
  logic [15:0] dout_r, rdata_r;

  // State register with per-state down-counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: each phase lasts its cycle count, then loads the next phase's count
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
          cnt_s    = SETUP_LD;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_STROBE;
          cnt_s   = STROBE_LD;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_HOLD;
          cnt_s   = HOLD_LD;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RECOVER;
          cnt_s   = RECOVER_LD;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Pin values for the state being entered; on accept the request fields bypass the capture flops
  always_comb begin
    write_s  = accept_s ? bus.req_write : write_r;
    active_s = (state_s == ST_SETUP) || (state_s == ST_STROBE) || (state_s == ST_HOLD);
    strobe_s = (state_s == ST_STROBE);
    cs_n_s   = ~active_s;
    oe_s     = active_s & write_s;
    ior_n_s  = ~(strobe_s & ~write_s);
    iow_n_s  = ~(strobe_s & write_s);
    sample_s = (state_r == ST_STROBE) && (cnt_r == 4'd0);
  end

  // Pin, capture and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_n_r      <= 1'b1;
      ior_n_r     <= 1'b1;
      iow_n_r     <= 1'b1;
      oe_r        <= 1'b0;
      cmd_r       <= 1'b0;
      dout_r      <= 16'h0000;
      write_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= 16'h0000;
    end else begin
      cs_n_r      <= cs_n_s;
      ior_n_r     <= ior_n_s;
      iow_n_r     <= iow_n_s;
      oe_r        <= oe_s;
      rsp_valid_r <= sample_s;
      if (accept_s) begin
        write_r <= bus.req_write;
        cmd_r   <= bus.req_cmd;
        if (bus.req_write) begin
          dout_r <= bus.req_wdata;
        end
      end
      // Read data is latched on the edge that closes the last strobe cycle
      if (sample_s && !write_r) begin
        rdata_r <= bus.enet_data_in;
      end
    end
  end

  assign bus.req_ready     = (state_r == ST_IDLE);
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_rdata     = rdata_r;
  assign bus.enet_cs_n     = cs_n_r;
  assign bus.enet_cmd      = cmd_r;
  assign bus.enet_ior_n    = ior_n_r;
  assign bus.enet_iow_n    = iow_n_r;
  assign bus.enet_data_out = dout_r;
  assign bus.enet_data_oe  = oe_r;

endmodule

// File: tb/tb_dm9000a_bus_ctrl.sv
// Bench for dm9000a_bus_ctrl: a default-timing and a swept-timing instance share one request stream;
// each has a cycle-timing model of the pins and a response scoreboard.
module tb_dm9000a_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_write, req_cmd;
  logic [15:0] req_wdata, rd_pat;
  logic        b2b = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc_no = 0;
  int          n0, n1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  dm9000a_bus_ctrl_if bus[2] ();

  dm9000a_bus_ctrl dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus[0])
  );

  dm9000a_bus_ctrl #(
    .SETUP_CYC   (2),
    .STROBE_CYC  (4),
    .HOLD_CYC    (3),
    .RECOVER_CYC (1)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int S   = (g == 0) ? 1 : 2;
    localparam int T   = (g == 0) ? 2 : 4;
    localparam int H   = (g == 0) ? 1 : 3;
    localparam int R   = (g == 0) ? 2 : 1;
    localparam int TOT = S + T + H + R;

    logic [15:0] q[$];
    logic        active = 1'b0;
    int          cyc = 0;
    logic        wr_c = 1'b0;
    logic        cmd_m = 1'b0;
    logic [15:0] dout_m = 16'h0000;
    logic [15:0] last_rd = 16'h0000;
    logic [15:0] rd_c = 16'h0000;
    logic [15:0] din;
    int          prev_acc = 0;
    logic        prev_ok = 1'b0;
    int          acc_cnt = 0;

    assign bus[g].req_valid    = req_valid;
    assign bus[g].req_write    = req_write;
    assign bus[g].req_cmd      = req_cmd;
    assign bus[g].req_wdata    = req_wdata;
    assign bus[g].enet_data_in = din;

    // Accept detection, cycle position model, scoreboard push
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        active  <= 1'b0;
        cyc     <= 0;
        cmd_m   <= 1'b0;
        dout_m  <= 16'h0000;
        last_rd <= 16'h0000;
        prev_ok <= 1'b0;
        q.delete();
      end else if (bus[g].req_valid && bus[g].req_ready) begin
        active  <= 1'b1;
        cyc     <= 1;
        wr_c    <= req_write;
        cmd_m   <= req_cmd;
        rd_c    <= rd_pat;
        acc_cnt <= acc_cnt + 1;
        if (req_write) begin
          dout_m <= req_wdata;
          q.push_back(last_rd);
        end else begin
          last_rd <= rd_pat;
          q.push_back(rd_pat);
        end
        if (b2b && prev_ok) check_val($sformatf("d%0d_accept_gap", g), 32'(cyc_no - prev_acc), 32'(TOT + 1));
        prev_acc <= cyc_no;
        prev_ok  <= b2b;
      end else if (active) begin
        if (cyc == TOT) active <= 1'b0;
        else cyc <= cyc + 1;
      end
    end

    // Pin timing checks and scoreboard pop, away from the active edge
    always @(negedge clk) begin
      if (reset_n) begin
        check_val($sformatf("d%0d_cs_n", g), 32'(bus[g].enet_cs_n), active ? 32'(cyc > S + T + H) : 32'd1);
        check_val($sformatf("d%0d_oe", g), 32'(bus[g].enet_data_oe), active ? 32'(wr_c && cyc <= S + T + H) : 32'd0);
        check_val($sformatf("d%0d_ior_n", g), 32'(bus[g].enet_ior_n),
                  32'(!(active && !wr_c && cyc > S && cyc <= S + T)));
        check_val($sformatf("d%0d_iow_n", g), 32'(bus[g].enet_iow_n),
                  32'(!(active && wr_c && cyc > S && cyc <= S + T)));
        check_val($sformatf("d%0d_rsp_valid", g), 32'(bus[g].rsp_valid), 32'(active && cyc == S + T + 1));
        check_val($sformatf("d%0d_req_ready", g), 32'(bus[g].req_ready), 32'(!active));
        check_val($sformatf("d%0d_cmd", g), 32'(bus[g].enet_cmd), 32'(cmd_m));
        check_val($sformatf("d%0d_data_out", g), 32'(bus[g].enet_data_out), 32'(dout_m));
        if (bus[g].rsp_valid && q.size() > 0)
          check_val($sformatf("d%0d_rsp_rdata", g), 32'(bus[g].rsp_rdata), 32'(q.pop_front()));
      end
    end

    // Pad data: the read value during strobe (swept instance: only in its last strobe cycle)
    initial begin
      din = 16'hFFFF;
      forever begin
        @(posedge clk);
        #1;
        if (active && cyc > S && cyc <= S + T)
          din = (g == 1 && cyc != S + T) ? 16'h1234 : rd_c;
        else
          din = 16'hFFFF;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus[0].req_ready && bus[1].req_ready;
    end
    if (!ok) check_val("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(input logic wr, input logic cmd, input logic [15:0] wd, input logic [15:0] rd,
                      input bit tog);
    wait_idle();
    req_write = wr;
    req_cmd   = cmd;
    req_wdata = wd;
    rd_pat    = rd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (tog) begin
      for (int i = 0; i < 12; i++) begin
        req_wdata = 16'($urandom);
        req_cmd   = ~req_cmd;
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_cmd   = 1'b0;
    req_wdata = 16'h0000;
    rd_pat    = 16'h0000;
    #12;
    check_val("rst_cs_n0", 32'(bus[0].enet_cs_n), 32'd1);
    check_val("rst_ior_n0", 32'(bus[0].enet_ior_n), 32'd1);
    check_val("rst_iow_n0", 32'(bus[0].enet_iow_n), 32'd1);
    check_val("rst_cmd0", 32'(bus[0].enet_cmd), 32'd0);
    check_val("rst_dout0", 32'(bus[0].enet_data_out), 32'd0);
    check_val("rst_oe0", 32'(bus[0].enet_data_oe), 32'd0);
    check_val("rst_rsp_valid0", 32'(bus[0].rsp_valid), 32'd0);
    check_val("rst_rdata0", 32'(bus[0].rsp_rdata), 32'd0);
    check_val("rst_cs_n1", 32'(bus[1].enet_cs_n), 32'd1);
    check_val("rst_rdata1", 32'(bus[1].rsp_rdata), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rdy_after_rst0", 32'(bus[0].req_ready), 32'd1);
    check_val("rdy_after_rst1", 32'(bus[1].req_ready), 32'd1);

    send(1'b1, 1'b0, 16'h0028, 16'h0000, 1'b0);
    send(1'b0, 1'b1, 16'h0000, 16'h0A46, 1'b0);
    send(1'b1, 1'b1, 16'hBEEF, 16'h0000, 1'b1);
    send(1'b0, 1'b0, 16'h7777, 16'h5A5A, 1'b1);
    send(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Back-to-back: valid held across three accepts of the default instance
    wait_idle();
    n0 = g_mon[0].acc_cnt;
    n1 = g_mon[1].acc_cnt;
    b2b       = 1'b1;
    req_write = 1'b0;
    req_cmd   = 1'b1;
    rd_pat    = 16'hC3C3;
    req_valid = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_val("b2b_count0", 32'(g_mon[0].acc_cnt - n0), 32'd3);
    check_val("b2b_count1", 32'(g_mon[1].acc_cnt - n1), 32'd2);
    wait_idle();
    b2b = 1'b0;

    // Reset in the middle of the default instance's write strobe
    wait_idle();
    req_write = 1'b1;
    req_cmd   = 1'b0;
    req_wdata = 16'hA5A5;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("pre_rst_iow_n0", 32'(bus[0].enet_iow_n), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_iow_n0", 32'(bus[0].enet_iow_n), 32'd1);
    check_val("mid_rst_cs_n0", 32'(bus[0].enet_cs_n), 32'd1);
    check_val("mid_rst_oe0", 32'(bus[0].enet_data_oe), 32'd0);
    check_val("mid_rst_cs_n1", 32'(bus[1].enet_cs_n), 32'd1);
    check_val("mid_rst_rsp0", 32'(bus[0].rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rdy_after_mid_rst0", 32'(bus[0].req_ready), 32'd1);
    check_val("rdy_after_mid_rst1", 32'(bus[1].req_ready), 32'd1);

    send(1'b0, 1'b1, 16'h0000, 16'h8001, 1'b0);
    send(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    check_val("sb_empty0", 32'(g_mon[0].q.size()), 32'd0);
    check_val("sb_empty1", 32'(g_mon[1].q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
